// File: rtl/serial_tx_enable_pkg.sv
// Shared state encodings and line constants for the serial frame transmitter.
// The optional parity stage is enabled by defining SERIAL_TX_PARITY_EN.
package serial_tx_enable_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARMED = 3'd1,
        S_START = 3'd2,
        S_DATA  = 3'd3,
        S_PAR   = 3'd4,
        S_STOP  = 3'd5
    } tx_state_t;

    localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/serial_tx_enable_tx_shift_reg.sv
// Word-wide shift register: parallel load, then right shift one bit per step.
// The line bit is always taken from the LSB.
module tx_shift_reg #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              shift,
    input  logic [DATA_W-1:0] d,
    output logic              lsb
);

    logic [DATA_W-1:0] q;

    always_ff @(posedge clk) begin
        if (reset)
            q <= '0;
        else if (load)
            q <= d;
        else if (shift)
            q <= q >> 1;
    end

    assign lsb = q[0];

endmodule

// File: rtl/serial_tx_enable.sv
// Parallel-in serial-out frame transmitter: start 0, data LSB-first, stop 1.
// Define SERIAL_TX_PARITY_EN to insert an even parity bit before the stop bit.
module serial_tx_enable
    import serial_tx_enable_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_valid,
    output logic              data_ready,
    output logic              tx,
    output logic              busy,
    output logic              done
);

    tx_state_t        state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             tx_nx, done_nx, load, shift, lsb;

    tx_shift_reg #(.DATA_W(DATA_W)) u_shift (
        .clk  (clk),
        .reset(reset),
        .load (load),
        .shift(shift),
        .d    (data_in),
        .lsb  (lsb)
    );

`ifdef SERIAL_TX_PARITY_EN
    // Parity is captured at acceptance because the shift register consumes the word.
    logic par_bit;

    always_ff @(posedge clk) begin
        if (reset)
            par_bit <= 1'b0;
        else if (load)
            par_bit <= ^data_in;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= '0;
            tx    <= IDLE_LEVEL;
            done  <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            tx    <= tx_nx;
            done  <= done_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        tx_nx    = tx;
        done_nx  = 1'b0;
        load     = 1'b0;
        shift    = 1'b0;
        // Acceptance in IDLE ignores en; every other move waits for the bit strobe.
        case (state)
            S_IDLE: begin
                if (data_valid) begin
                    load     = 1'b1;
                    state_nx = S_ARMED;
                end
            end
            S_ARMED: begin
                if (en) begin
                    state_nx = S_START;
                    tx_nx    = 1'b0;
                end
            end
            S_START: begin
                if (en) begin
                    state_nx = S_DATA;
                    tx_nx    = lsb;
                    shift    = 1'b1;
                    cnt_nx   = CNT_W'(1);
                end
            end
            S_DATA: begin
                if (en) begin
                    if (cnt < CNT_W'(DATA_W)) begin
                        tx_nx  = lsb;
                        shift  = 1'b1;
                        cnt_nx = cnt + CNT_W'(1);
                    end else begin
`ifdef SERIAL_TX_PARITY_EN
                        state_nx = S_PAR;
                        tx_nx    = par_bit;
`else
                        state_nx = S_STOP;
                        tx_nx    = IDLE_LEVEL;
`endif
                    end
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            S_PAR: begin
                if (en) begin
                    state_nx = S_STOP;
                    tx_nx    = IDLE_LEVEL;
                end
            end
`endif
            S_STOP: begin
                if (en) begin
                    state_nx = S_IDLE;
                    tx_nx    = IDLE_LEVEL;
                    done_nx  = 1'b1;
                end
            end
            default: begin
                state_nx = S_IDLE;
                tx_nx    = IDLE_LEVEL;
            end
        endcase
    end

    assign data_ready = (state == S_IDLE);
    assign busy       = (state != S_IDLE);

endmodule

// File: tb/tb_serial_tx_enable.sv
// Randomized scoreboard bench for serial_tx_enable: a monitor rebuilds every frame from
// the queued words and checks the line, done and busy cycle by cycle.
module tb_serial_tx_enable;

    localparam int DATA_W = 8;
`ifdef SERIAL_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int STOP_POS = DATA_W + 1 + PAR;

    logic clk = 1'b0;
    logic reset, en, data_valid, data_ready, tx, busy, done;
    logic [DATA_W-1:0] data_in;

    int total = 0;
    int bad = 0;
    logic [DATA_W-1:0] exp_q[$];
    int en_mode = 1;
    int en_cnt = 0;

    // Monitor frame tracker
    logic              inframe = 1'b0;
    int                pos = 0;
    logic [DATA_W-1:0] cur_w;
    logic              en_s, rst_s, ended;

    always #5 clk = ~clk;

    serial_tx_enable #(.DATA_W(DATA_W), .CNT_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .data_in   (data_in),
        .data_valid(data_valid),
        .data_ready(data_ready),
        .tx        (tx),
        .busy      (busy),
        .done      (done)
    );

    // Line level of frame position p: 0 start, 1..DATA_W data, optional parity, then stop.
    function automatic logic expbit(input logic [DATA_W-1:0] w, input int p);
        if (p == 0) return 1'b0;
        if (p <= DATA_W) return w[p-1];
        if (PAR == 1 && p == DATA_W + 1) return ^w;
        return 1'b1;
    endfunction

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // One clock of stimulus; en follows the current mode
    task automatic cyc();
        @(negedge clk);
        case (en_mode)
            0: en = 1'b0;
            1: en = 1'b1;
            2: en = ($urandom_range(0, 2) == 0);
            default: begin
                en = (en_cnt % 4 == 0);
                en_cnt++;
            end
        endcase
    endtask

    // Offer w until accepted; while busy, data_in carries garbage that must be ignored.
    task automatic applyStimulus(input logic [DATA_W-1:0] w);
        int accepted = 0;
        for (int i = 0; i < 2000 && accepted == 0; i++) begin
            cyc();
            data_valid = 1'b1;
            if (data_ready) begin
                data_in = w;
                exp_q.push_back(w);
                accepted = 1;
            end else begin
                data_in = DATA_W'($urandom);
            end
        end
        cyc();
        data_valid = 1'b0;
        data_in = DATA_W'($urandom);
        check("accept", accepted, 1);
    endtask

    task automatic waitIdle();
        for (int i = 0; i < 3000 && !(exp_q.size() == 0 && data_ready); i++) cyc();
        check("drain", exp_q.size(), 0);
    endtask

    task automatic checkOutput(input string name, input logic t, input logic b,
                               input logic r, input logic d);
        check({name, "_tx"}, int'(tx), int'(t));
        check({name, "_busy"}, int'(busy), int'(b));
        check({name, "_ready"}, int'(data_ready), int'(r));
        check({name, "_done"}, int'(done), int'(d));
    endtask

    // Scoreboard monitor: expected line comes from the queued word and the frame position.
    always @(posedge clk) begin
        en_s  = en;
        rst_s = reset;
        #1;
        ended = 1'b0;
        if (rst_s) begin
            inframe = 1'b0;
        end else begin
            if (inframe && en_s && pos == STOP_POS) begin
                ended   = 1'b1;
                inframe = 1'b0;
                void'(exp_q.pop_front());
                check("end_busy", int'(busy), 0);
                check("end_ready", int'(data_ready), 1);
            end else if (inframe && en_s) begin
                pos++;
            end
            if (!inframe && !ended && en_s && tx == 1'b0) begin
                check("start_has_word", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    inframe = 1'b1;
                    pos     = 0;
                    cur_w   = exp_q[0];
                end
            end
            if (inframe)
                check("line_bit", int'(tx), int'(expbit(cur_w, pos)));
            else
                check("idle_line", int'(tx), 1);
            check("done", int'(done), int'(ended));
        end
    end

    initial begin
        logic [DATA_W-1:0] w;
        reset = 1'b1;
        en = 1'b0;
        data_valid = 1'b0;
        data_in = '0;
        repeat (3) cyc();
        checkOutput("reset", 1'b1, 1'b0, 1'b1, 1'b0);
        reset = 1'b0;
        repeat (2) cyc();

        // Basic frame with en every 4th cycle
        en_mode = 3;
        applyStimulus(8'hA5);
        waitIdle();

        // Exact latency with en held high
        en_mode = 1;
        w = 8'h07;
        applyStimulus(w);
        for (int i = 1; i <= STOP_POS + 2; i++) begin
            @(posedge clk);
            #1;
            if (i <= STOP_POS + 1) check($sformatf("lat_tx_%0d", i), int'(tx), int'(expbit(w, i - 1)));
            check($sformatf("lat_done_%0d", i), int'(done), int'(i == STOP_POS + 2));
        end
        waitIdle();

        // Words offered while busy are not sampled
        applyStimulus(8'h3C);
        applyStimulus(8'hFF);
        waitIdle();

        // Reset during data bit 3 aborts the frame
        applyStimulus(8'hA5);
        repeat (5) cyc();
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("midreset", 1'b1, 1'b0, 1'b1, 1'b0);
        exp_q.delete();
        cyc();
        reset = 1'b0;
        applyStimulus(8'h81);
        waitIdle();

        // No en for 50 cycles keeps the frame armed
        en_mode = 0;
        applyStimulus(8'h5A);
        repeat (50) cyc();
        checkOutput("armed_hold", 1'b1, 1'b1, 1'b0, 1'b0);
        en_mode = 1;
        waitIdle();

        // Back-to-back frames
        applyStimulus(8'h00);
        applyStimulus(8'hFF);
        waitIdle();

        // Randomized traffic
        for (int n = 0; n < 40; n++) begin
            en_mode = $urandom_range(1, 3);
            applyStimulus(DATA_W'($urandom));
            repeat ($urandom_range(0, 3)) cyc();
        end
        en_mode = 1;
        waitIdle();

        repeat (4) cyc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
